// File: rtl/uart_tx_gen2_if.sv
// -----------------------------------------------------------------------------
// uart_tx_gen2_if
// Write-side bundle between the register block (master) and the uart_tx_gen2
// TX FIFO (slave).
//   i_fifo_wr_en    master->slave  push i_fifo_wr_data into the TX FIFO
//   i_fifo_wr_data  master->slave  character, LSB transmitted first
//   i_fifo_clear    master->slave  flush the FIFO
//   o_fifo_full     slave->master  FIFO holds DEPTH entries
//   o_fifo_empty    slave->master  FIFO holds no entries
//   o_level         slave->master  FIFO occupancy
// -----------------------------------------------------------------------------
interface uart_tx_gen2_if #(
  parameter int DATA_W = 9,
  parameter int LVL_W  = 5
);
  logic              i_fifo_wr_en;
  logic [DATA_W-1:0] i_fifo_wr_data;
  logic              i_fifo_clear;
  logic              o_fifo_full;
  logic              o_fifo_empty;
  logic [LVL_W-1:0]  o_level;

  modport master (
    output i_fifo_wr_en, i_fifo_wr_data, i_fifo_clear,
    input  o_fifo_full, o_fifo_empty, o_level
  );

  modport slave (
    input  i_fifo_wr_en, i_fifo_wr_data, i_fifo_clear,
    output o_fifo_full, o_fifo_empty, o_level
  );
endinterface

// File: rtl/uart_tx_gen2.sv
// -----------------------------------------------------------------------------
// uart_tx_gen2
// UART transmitter with integrated baud divider and TX FIFO. Characters of
// 5..MAX_DATA_BITS bits are sent LSB first with optional parity (even, odd,
// mark, space) and one or two stop bits. Break holds the line low between
// frames; releasing it inserts one high bit period before the next frame.
//
// Optional feature macro: UART_TX_CTS_EN
//   defined   : i_cts_n is synchronised (2 flops); frames start only while
//               the synchronised cts_n is low.
//   undefined : i_cts_n is ignored.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   i_baud_div        bit period = i_baud_div+1 clk cycles
//   i_data_bits       data bits per char, clamped to [5, MAX_DATA_BITS]
//   i_use_parity      append parity bit
//   i_parity_mode     00 even, 01 odd, 10 mark, 11 space
//   i_stop_bits       0 = one stop bit, 1 = two
//   i_break           hold line low (never truncates a frame)
//   i_threshold       level threshold for o_threshold
//   fifo_if           FIFO write/clear/status bundle (slave side)
//   i_err_clr         clear o_overflow_error
//   i_cts_n           clear-to-send, active low
//   o_threshold       registered (level <= i_threshold)
//   o_overflow_error  sticky: write attempted while full
//   o_busy            FSM not idle
//   o_tx_done         one-cycle pulse in the last cycle of the last stop bit
//   o_uart_tx         registered serial line
// -----------------------------------------------------------------------------
module uart_tx_gen2 #(
  parameter int FIFO_DEPTH    = 16,
  parameter int MAX_DATA_BITS = 9,
  parameter int DIV_W         = 16,
  localparam int LVL_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIV_W-1:0]   i_baud_div,
  input  logic [3:0]         i_data_bits,
  input  logic               i_use_parity,
  input  logic [1:0]         i_parity_mode,
  input  logic               i_stop_bits,
  input  logic               i_break,
  input  logic [LVL_W-1:0]   i_threshold,
  uart_tx_gen2_if.slave      fifo_if,
  input  logic               i_err_clr,
  input  logic               i_cts_n,
  output logic               o_threshold,
  output logic               o_overflow_error,
  output logic               o_busy,
  output logic               o_tx_done,
  output logic               o_uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP0, S_STOP1, S_BREAK, S_GAP
  } state_t;

  // ---------------------------------------------------------------------------
  // Clear-to-send gating
  // ---------------------------------------------------------------------------
  logic cts_ok;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync_q;

  // Resets to "not clear to send" so nothing leaves before the pin is seen.
  always_ff @(posedge clk) begin
    if (rst) cts_sync_q <= 2'b11;
    else     cts_sync_q <= {cts_sync_q[0], i_cts_n};
  end

  assign cts_ok = ~cts_sync_q[1];
`else
  logic unused_cts;
  assign unused_cts = i_cts_n;
  assign cts_ok     = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [MAX_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]         level_q;
  logic                     fifo_full, fifo_empty;
  logic                     pop, push, ovf_set;
  logic [MAX_DATA_BITS-1:0] rd_data;

  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign rd_data    = mem[rd_ptr_q];

  // A write into a full FIFO is still accepted when a pop frees a slot in the
  // same cycle; clear discards any concurrent write without flagging overflow.
  assign push    = fifo_if.i_fifo_wr_en && !fifo_if.i_fifo_clear && (!fifo_full || pop);
  assign ovf_set = fifo_if.i_fifo_wr_en && !fifo_if.i_fifo_clear && fifo_full && !pop;

  // NOTE: storage array has no reset; only pointers and level need one, and
  // leaving it out lets the array map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= fifo_if.i_fifo_wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || fifo_if.i_fifo_clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign fifo_if.o_fifo_full  = fifo_full;
  assign fifo_if.o_fifo_empty = fifo_empty;
  assign fifo_if.o_level      = level_q;

  // ---------------------------------------------------------------------------
  // Frame configuration sampled at launch
  // ---------------------------------------------------------------------------
  logic [3:0]               n_launch;
  logic [MAX_DATA_BITS-1:0] data_masked;
  logic                     par_launch;

  always_comb begin
    n_launch = i_data_bits;
    if (i_data_bits < 4'd5)                  n_launch = 4'd5;
    if (i_data_bits > 4'(MAX_DATA_BITS))     n_launch = 4'(MAX_DATA_BITS);
  end

  // Bits above the configured width are zeroed so they affect neither the
  // shifted data nor the parity.
  always_comb begin
    data_masked = '0;
    for (int i = 0; i < MAX_DATA_BITS; i++)
      data_masked[i] = rd_data[i] && (4'(i) < n_launch);
  end

  always_comb begin
    case (i_parity_mode)
      2'b00:   par_launch = ^data_masked;
      2'b01:   par_launch = ~^data_masked;
      2'b10:   par_launch = 1'b1;
      default: par_launch = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  state_t                   state_q, state_d;
  logic [DIV_W-1:0]         cnt_q, div_q, reload;
  logic [MAX_DATA_BITS-1:0] sh_q, sh_d;
  logic [3:0]               bit_cnt_q, nbits_q;
  logic                     par_en_q, par_q, stop2_q;
  logic                     tick, can_launch, launch, gap_enter, done, tx_d;

  assign tick       = (cnt_q == '0);
  assign can_launch = !fifo_empty && !i_break && cts_ok;
  assign pop        = launch;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    launch    = 1'b0;
    gap_enter = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_break) begin
          state_d = S_BREAK;
        end else if (can_launch) begin
          state_d = S_START;
          launch  = 1'b1;
        end
      end
      S_START:  if (tick) state_d = S_DATA;
      S_DATA: begin
        if (tick && (bit_cnt_q == nbits_q - 4'd1))
          state_d = par_en_q ? S_PARITY : S_STOP0;
      end
      S_PARITY: if (tick) state_d = S_STOP0;
      S_STOP0: begin
        if (tick) begin
          if (stop2_q) begin
            state_d = S_STOP1;
          end else begin
            done    = 1'b1;
            state_d = i_break ? S_BREAK : S_IDLE;
          end
        end
      end
      S_STOP1: begin
        if (tick) begin
          done    = 1'b1;
          state_d = i_break ? S_BREAK : S_IDLE;
        end
      end
      S_BREAK: begin
        if (!i_break) begin
          state_d   = S_GAP;
          gap_enter = 1'b1;
        end
      end
      S_GAP: begin
        // Launching straight out of the gap keeps the idle-high time at
        // exactly one bit period before a queued frame.
        if (tick) begin
          if (i_break) begin
            state_d = S_BREAK;
          end else if (can_launch) begin
            state_d = S_START;
            launch  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The divider restarts on every state change and on every tick, so each
  // bit lasts exactly div+1 cycles.
  assign reload = (launch || gap_enter) ? i_baud_div : div_q;

  // Line value is computed from the next state so o_uart_tx can be a flop
  // that changes on the same edge as the state.
  always_comb begin
    sh_d = sh_q;
    if (launch)                         sh_d = data_masked;
    else if (state_q == S_DATA && tick) sh_d = sh_q >> 1;
    case (state_d)
      S_START, S_BREAK: tx_d = 1'b0;
      S_DATA:           tx_d = sh_d[0];
      S_PARITY:         tx_d = par_q;
      default:          tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      nbits_q   <= 4'd5;
      par_en_q  <= 1'b0;
      par_q     <= 1'b0;
      stop2_q   <= 1'b0;
      o_uart_tx <= 1'b1;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      o_uart_tx <= tx_d;

      if ((state_d != state_q) || tick) cnt_q <= reload;
      else                              cnt_q <= cnt_q - DIV_W'(1);

      if (launch || gap_enter) div_q <= i_baud_div;

      if (launch) begin
        bit_cnt_q <= '0;
        nbits_q   <= n_launch;
        par_en_q  <= i_use_parity;
        par_q     <= par_launch;
        stop2_q   <= i_stop_bits;
      end else if (state_q == S_DATA && tick) begin
        bit_cnt_q <= bit_cnt_q + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      o_threshold      <= 1'b0;
      o_overflow_error <= 1'b0;
    end else begin
      o_threshold <= (level_q <= i_threshold);
      if (ovf_set)        o_overflow_error <= 1'b1;
      else if (i_err_clr) o_overflow_error <= 1'b0;
    end
  end

  assign o_busy    = (state_q != S_IDLE);
  assign o_tx_done = done;

endmodule

// File: tb/tb_uart_tx_gen2.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_gen2
// Directed self-checking bench for uart_tx_gen2: reset values, framing at
// several divisors/formats, data-width clamping, overflow handling, break and
// gap timing, threshold/clear behaviour, reset mid-frame, and (when built with
// UART_TX_CTS_EN) clear-to-send gating.
// -----------------------------------------------------------------------------
module tb_uart_tx_gen2;

  localparam int FIFO_DEPTH    = 16;
  localparam int MAX_DATA_BITS = 9;
  localparam int DIV_W         = 16;
  localparam int LVL_W         = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [DIV_W-1:0] i_baud_div;
  logic [3:0]       i_data_bits;
  logic             i_use_parity;
  logic [1:0]       i_parity_mode;
  logic             i_stop_bits;
  logic             i_break;
  logic [LVL_W-1:0] i_threshold;
  logic             i_err_clr;
  logic             i_cts_n;
  logic             o_threshold;
  logic             o_overflow_error;
  logic             o_busy;
  logic             o_tx_done;
  logic             o_uart_tx;

  uart_tx_gen2_if #(.DATA_W(MAX_DATA_BITS), .LVL_W(LVL_W)) fifo_if ();

  uart_tx_gen2 #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .MAX_DATA_BITS(MAX_DATA_BITS),
    .DIV_W        (DIV_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_baud_div      (i_baud_div),
    .i_data_bits     (i_data_bits),
    .i_use_parity    (i_use_parity),
    .i_parity_mode   (i_parity_mode),
    .i_stop_bits     (i_stop_bits),
    .i_break         (i_break),
    .i_threshold     (i_threshold),
    .fifo_if         (fifo_if),
    .i_err_clr       (i_err_clr),
    .i_cts_n         (i_cts_n),
    .o_threshold     (o_threshold),
    .o_overflow_error(o_overflow_error),
    .o_busy          (o_busy),
    .o_tx_done       (o_tx_done),
    .o_uart_tx       (o_uart_tx)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit exp_bits[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [8:0] data);
    fifo_if.i_fifo_wr_en   = 1'b1;
    fifo_if.i_fifo_wr_data = data;
    step();
    fifo_if.i_fifo_wr_en   = 1'b0;
  endtask

  task automatic set_cfg(input int div, input int nb, input bit par, input logic [1:0] mode,
                         input bit stop2);
    i_baud_div    = DIV_W'(div);
    i_data_bits   = 4'(nb);
    i_use_parity  = par;
    i_parity_mode = mode;
    i_stop_bits   = stop2;
  endtask

  // Expected line sequence: start, nb data bits LSB first, optional parity
  // (par < 0 means none), nstop stop bits.
  task automatic push_frame(input logic [8:0] data, input int nb, input int par, input int nstop);
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) exp_bits.push_back(data[i]);
    if (par >= 0) exp_bits.push_back(par[0]);
    for (int i = 0; i < nstop; i++) exp_bits.push_back(1'b1);
  endtask

  // Called while the first cycle of the start bit is being sampled; returns
  // while sampling the last cycle of the last stop bit.
  task automatic expect_frame(input string tag, input int div);
    int total;
    int b;
    total = exp_bits.size() * (div + 1);
    for (int k = 0; k < total; k++) begin
      b = k / (div + 1);
      check($sformatf("%s_bit%0d_cyc%0d", tag, b, k % (div + 1)), o_uart_tx, exp_bits[b]);
      if (k == total - 1)
        check({tag, "_done"}, o_tx_done, 1);
      else if (k % (div + 1) == 0)
        check({tag, "_nodone"}, o_tx_done, 0);
      if (k != total - 1) step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [8:0] d;
    bit         seen;

    rst                    = 1'b1;
    i_break                = 1'b0;
    i_threshold            = '0;
    i_err_clr              = 1'b0;
    i_cts_n                = 1'b0;
    fifo_if.i_fifo_wr_en   = 1'b0;
    fifo_if.i_fifo_wr_data = '0;
    fifo_if.i_fifo_clear   = 1'b0;
    set_cfg(3, 8, 0, 2'b00, 0);

    // ---- reset values ----
    step();
    step();
    check("rst_tx",        o_uart_tx, 1);
    check("rst_busy",      o_busy, 0);
    check("rst_done",      o_tx_done, 0);
    check("rst_ovf",       o_overflow_error, 0);
    check("rst_thr",       o_threshold, 0);
    check("rst_empty",     fifo_if.o_fifo_empty, 1);
    check("rst_full",      fifo_if.o_fifo_full, 0);
    check("rst_level",     fifo_if.o_level, 0);
    rst = 1'b0;
    step();
    step();
    step();

    // ---- 1: div=3, 8N1, 0xA5 ----
    write_word(9'h0A5);
    check("t1_lat_edge1_tx", o_uart_tx, 1);
    check("t1_level1",       fifo_if.o_level, 1);
    step();
    check("t1_busy",         o_busy, 1);
    check("t1_level0",       fifo_if.o_level, 0);
    push_frame(9'h0A5, 8, -1, 1);
    expect_frame("t1", 3);
    step();
    check("t1_idle_tx",   o_uart_tx, 1);
    check("t1_idle_busy", o_busy, 0);
    check("t1_idle_done", o_tx_done, 0);

    // ---- 2: div=0, 7O2 0x41 (1000001 -> odd parity 1), then 9N1 0x1FF ----
    set_cfg(0, 7, 1, 2'b01, 1);
    write_word(9'h041);
    step();
    push_frame(9'h041, 7, 1, 2);
    expect_frame("t2a", 0);
    step();
    check("t2a_idle", o_uart_tx, 1);
    set_cfg(0, 9, 0, 2'b00, 0);
    write_word(9'h1FF);
    step();
    push_frame(9'h1FF, 9, -1, 1);
    expect_frame("t2b", 0);
    step();
    check("t2b_idle", o_uart_tx, 1);

    // ---- 2c: 3 bits clamps to 5; 0x0EA sends 0,1,0,1,0; even parity 0 ----
    set_cfg(1, 3, 1, 2'b00, 0);
`ifndef UART_TX_CTS_EN
    i_cts_n = 1'b1;
`endif
    write_word(9'h0EA);
    step();
    push_frame(9'h00A, 5, 0, 1);
    expect_frame("t2c", 1);
    step();
    check("t2c_idle", o_uart_tx, 1);
    i_cts_n = 1'b0;

    // ---- 3: overflow ----
    set_cfg(0, 8, 0, 2'b00, 0);
    i_break = 1'b1;
    step();
    check("t3_break_tx", o_uart_tx, 0);
    check("t3_break_busy", o_busy, 1);
    for (int i = 0; i < 16; i++) write_word(9'(8'h10 + i));
    check("t3_level16", fifo_if.o_level, 16);
    check("t3_full",    fifo_if.o_fifo_full, 1);
    check("t3_ovf0",    o_overflow_error, 0);
    write_word(9'h033);
    check("t3_ovf1",    o_overflow_error, 1);
    check("t3_level_still16", fifo_if.o_level, 16);
    i_err_clr = 1'b1;
    write_word(9'h033);
    check("t3_set_wins", o_overflow_error, 1);
    step();
    i_err_clr = 1'b0;
    check("t3_errclr", o_overflow_error, 0);
    i_break = 1'b0;
    step();
    check("t3_gap_tx", o_uart_tx, 1);
    write_word(9'h05A);
    check("t3_wr_pop_level", fifo_if.o_level, 16);
    check("t3_wr_pop_ovf",   o_overflow_error, 0);
    for (int f = 0; f < 17; f++) begin
      d = (f < 16) ? 9'(8'h10 + f) : 9'h05A;
      push_frame(d, 8, -1, 1);
      expect_frame($sformatf("t3_f%0d", f), 0);
      step();
      check($sformatf("t3_f%0d_idle", f), o_uart_tx, 1);
      if (f < 16) step();
    end
    check("t3_drained_empty", fifo_if.o_fifo_empty, 1);
    check("t3_drained_busy",  o_busy, 0);

    // ---- 4: break mid-frame ----
    set_cfg(2, 8, 0, 2'b00, 0);
    write_word(9'h0C3);
    write_word(9'h096);
    check("t4_level", fifo_if.o_level, 1);
    i_break = 1'b1;
    push_frame(9'h0C3, 8, -1, 1);
    expect_frame("t4a", 2);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t4_hold%0d_tx", i), o_uart_tx, 0);
      check($sformatf("t4_hold%0d_lvl", i), fifo_if.o_level, 1);
    end
    i_break = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t4_gap%0d", i), o_uart_tx, 1);
    end
    step();
    push_frame(9'h096, 8, -1, 1);
    expect_frame("t4b", 2);
    step();
    check("t4_idle", o_busy, 0);

    // ---- 5: threshold and clear ----
    i_threshold = 5'd2;
    i_break = 1'b1;
    step();
    write_word(9'h001);
    write_word(9'h002);
    write_word(9'h003);
    step();
    check("t5_level3", fifo_if.o_level, 3);
    check("t5_thr0",   o_threshold, 0);
    i_break = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("t5_start",  o_uart_tx, 0);
    check("t5_level2", fifo_if.o_level, 2);
    step();
    check("t5_thr1",   o_threshold, 1);
    fifo_if.i_fifo_clear = 1'b1;
    write_word(9'h077);
    fifo_if.i_fifo_clear = 1'b0;
    check("t5_clr_level", fifo_if.o_level, 0);
    check("t5_clr_empty", fifo_if.o_fifo_empty, 1);
    check("t5_clr_ovf",   o_overflow_error, 0);
    check("t5_clr_busy",  o_busy, 1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (o_tx_done) seen = 1'b1;
      else step();
    end
    check("t5_frame_done", seen, 1);
    step();
    check("t5_idle_busy", o_busy, 0);
    step();
    check("t5_no_more_busy", o_busy, 0);
    check("t5_no_more_tx",   o_uart_tx, 1);

`ifdef UART_TX_CTS_EN
    // ---- 6: clear-to-send gating ----
    set_cfg(0, 8, 0, 2'b00, 0);
    i_cts_n = 1'b1;
    write_word(9'h055);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t6_blocked%0d", i), o_uart_tx, 1);
    end
    i_cts_n = 1'b0;
    step();
    check("t6_sync1", o_uart_tx, 1);
    step();
    check("t6_sync2", o_uart_tx, 1);
    step();
    i_cts_n = 1'b1;
    push_frame(9'h055, 8, -1, 1);
    expect_frame("t6", 0);
    step();
    check("t6_idle", o_busy, 0);
    i_cts_n = 1'b0;
    step();
    step();
`endif

    // ---- reset mid-frame ----
    set_cfg(3, 8, 0, 2'b00, 0);
    write_word(9'h000);
    step();
    step();
    step();
    check("rmf_in_frame", o_uart_tx, 0);
    rst = 1'b1;
    step();
    check("rmf_tx",   o_uart_tx, 1);
    check("rmf_busy", o_busy, 0);
    check("rmf_lvl",  fifo_if.o_level, 0);
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
